adc_frame_scheduler: RTL and testbench

Sequencer between the MCP3002 SPI driver and the OFDM demodulator. It generates the 48 kHz sample tick and issues one conversion request per tick. It writes each returned 10-bit sample into one bank of a two-bank (ping-pong) frame buffer and hands each full 1024-sample bank to the demodulator with a ready/ack handshake. It also flags missed ticks and frame overruns.

---
 rtl/adc_frame_scheduler_pkg.sv | 21 ++
 rtl/adc_frame_scheduler_sample_tick_gen.sv | 35 +++
 rtl/adc_frame_scheduler.sv | 142 ++++++++++++++
 tb/tb_adc_frame_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frame_scheduler_pkg.sv
// ============================================================================
// adc_frame_scheduler_pkg : shared defaults and FSM encoding for the scheduler
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_frame_scheduler_pkg;

    localparam int DEF_CLK_FREQ          = 24_000_000;
    localparam int DEF_ADC_SAMPLING_FREQ = 48_000;
    localparam int DEF_FRAME_LEN         = 1024;
    localparam int DEF_SAMPLE_W          = 10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/adc_frame_scheduler_sample_tick_gen.sv
// ============================================================================
// sample_tick_gen : free-running divider, one-cycle tick every CYCLE clocks
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_tick_gen #(
    parameter int CYCLE = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int            CNT_W    = (CYCLE > 1) ? $clog2(CYCLE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLE - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!enable || r_cnt == LAST_CNT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (r_cnt == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/adc_frame_scheduler.sv
// ============================================================================
// adc_frame_scheduler : ADC request sequencer feeding a ping-pong frame buffer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_frame_scheduler
    import adc_frame_scheduler_pkg::*;
#(
    parameter int CLK_FREQ          = DEF_CLK_FREQ,
    parameter int ADC_SAMPLING_FREQ = DEF_ADC_SAMPLING_FREQ,
    parameter int FRAME_LEN         = DEF_FRAME_LEN,
    parameter int SAMPLE_W          = DEF_SAMPLE_W,
    localparam int ADDR_W           = $clog2(FRAME_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    output logic                adc_start,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic                wr_en,
    output logic                wr_bank,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                frame_ready,
    output logic                frame_bank,
    input  logic                frame_ack,
    output logic                tick_miss,
    output logic                overrun,
    input  logic                clr_flags
);

    localparam int                CYCLE     = CLK_FREQ / ADC_SAMPLING_FREQ;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    state_t            r_state, w_state_nxt;
    logic              w_tick, w_start, w_miss, w_wr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_bank, r_oldest;
    logic [1:0]        r_full, w_full_nxt;
    logic              w_bank_nxt, w_oldest_nxt, w_ovr_set;
    logic              w_ack, w_done, w_other;

    sample_tick_gen #(.CYCLE(CYCLE)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_miss      = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_miss = w_tick;
                if (adc_valid) begin
                    w_wr        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bank bookkeeping acts on the registered write, so an ack in the same cycle is applied first.
    assign frame_ready = |r_full;
    assign frame_bank  = (r_full == 2'b11) ? r_oldest : r_full[1];
    assign w_ack       = frame_ack && frame_ready;
    assign w_done      = wr_en && (wr_addr == LAST_ADDR);
    assign w_other     = ~wr_bank;

    always_comb begin
        w_full_nxt   = r_full;
        w_bank_nxt   = r_bank;
        w_oldest_nxt = r_oldest;
        w_ovr_set    = 1'b0;
        if (w_ack) w_full_nxt[frame_bank] = 1'b0;
        if (w_done) begin
            if (!w_full_nxt[w_other]) begin
                w_full_nxt[wr_bank] = 1'b1;
                w_bank_nxt          = w_other;
            end else if (w_full_nxt[wr_bank]) begin
                // Both banks were already full: the overwritten bank is dropped.
                w_full_nxt[wr_bank] = 1'b0;
                w_ovr_set           = 1'b1;
            end else begin
                w_full_nxt[wr_bank] = 1'b1;
                w_oldest_nxt        = w_other;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_start <= 1'b0;
            wr_en     <= 1'b0;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            r_addr    <= '0;
            r_bank    <= 1'b0;
            r_full    <= 2'b00;
            r_oldest  <= 1'b0;
            tick_miss <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            adc_start <= w_start;
            wr_en     <= w_wr;
            if (w_wr) begin
                wr_bank <= r_bank;
                wr_addr <= r_addr;
                wr_data <= adc_data;
                r_addr  <= r_addr + ADDR_W'(1);
            end else if (r_state == S_IDLE && !enable) begin
                r_addr  <= '0;
            end
            r_bank    <= w_bank_nxt;
            r_full    <= w_full_nxt;
            r_oldest  <= w_oldest_nxt;
            tick_miss <= w_miss    | (tick_miss & ~clr_flags);
            overrun   <= w_ovr_set | (overrun   & ~clr_flags);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adc_frame_scheduler.sv
// ============================================================================
// tb_adc_frame_scheduler : directed table, timing sequences and random run
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_frame_scheduler;

    localparam int CLK_FREQ = 1000;
    localparam int ADC_SAMPLING_FREQ = 100;
    localparam int CYCLE = CLK_FREQ / ADC_SAMPLING_FREQ;
    localparam int FRAME_LEN = 8;
    localparam int SAMPLE_W = 10;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic adc_valid = 1'b0;
    logic frame_ack = 1'b0;
    logic clr_flags = 1'b0;
    logic [SAMPLE_W-1:0] adc_data = '0;
    logic adc_start, wr_en, wr_bank, frame_ready, frame_bank, tick_miss, overrun;
    logic [AW-1:0] wr_addr;
    logic [SAMPLE_W-1:0] wr_data;

    always #5 clk = ~clk;

    adc_frame_scheduler #(
        .CLK_FREQ(CLK_FREQ), .ADC_SAMPLING_FREQ(ADC_SAMPLING_FREQ),
        .FRAME_LEN(FRAME_LEN), .SAMPLE_W(SAMPLE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .adc_start(adc_start),
        .adc_valid(adc_valid), .adc_data(adc_data), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_ready(frame_ready),
        .frame_bank(frame_bank), .frame_ack(frame_ack), .tick_miss(tick_miss),
        .overrun(overrun), .clr_flags(clr_flags)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state: banks awaiting the consumer, oldest first.
    int  q[$];
    int  en_cnt, waddr, wbank;
    bit  outst, m_start, m_wr_en, m_wr_bank, m_miss, m_ovr;
    int  m_wr_addr;
    logic [SAMPLE_W-1:0] m_wr_data;

    // ADC model and recorders
    bit  pending, rand_mode;
    int  due, delay, samp_idx, nwr, rdy_rise, rdy_fall;
    int  start_q[$];
    int  wr_q[$];
    int  wa_q[$];

    typedef struct {
        int n; int delay; int ack_at; int clr_at; int dis_at; int dis_len;
        bit e_ready; bit e_bank; bit e_ovr; bit e_miss; int e_nwr;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qget(input int which, input int i);
        if (which == 0) return (i < start_q.size()) ? start_q[i] : -1;
        if (which == 1) return (i < wr_q.size()) ? wr_q[i] : -1;
        return (i < wa_q.size()) ? wa_q[i] : -1;
    endfunction

    function automatic bit in_q(input int b);
        foreach (q[i]) if (q[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        en_cnt = 0; waddr = 0; wbank = 0; outst = 0;
        m_start = 0; m_wr_en = 0; m_wr_bank = 0; m_wr_addr = 0; m_wr_data = '0;
        m_miss = 0; m_ovr = 0;
        pending = 0; due = 0; samp_idx = 0; nwr = 0; rdy_rise = -1; rdy_fall = -1;
        start_q.delete(); wr_q.delete(); wa_q.delete();
        cyc = 0;
    endtask

    task automatic model_step(input bit en, input bit valid, input logic [SAMPLE_W-1:0] data,
                              input bit ack, input bit clr);
        bit tick, start, miss_set, ovr_set, wr;
        int cb, ob;
        tick = en && (en_cnt % CYCLE == CYCLE - 1);
        en_cnt = en ? en_cnt + 1 : 0;
        start = tick && !outst;
        miss_set = tick && outst;
        ovr_set = 0;
        if (ack && q.size() > 0) void'(q.pop_front());
        if (m_wr_en && m_wr_addr == FRAME_LEN - 1) begin
            cb = m_wr_bank;
            ob = 1 - cb;
            if (!in_q(ob)) begin
                if (!in_q(cb)) q.push_back(cb);
                wbank = ob;
            end else if (in_q(cb)) begin
                ovr_set = 1;
                for (int i = 0; i < q.size(); i++) if (q[i] == cb) begin q.delete(i); break; end
            end else begin
                q.push_back(cb);
            end
        end
        wr = outst && valid;
        if (wr) begin
            m_wr_bank = wbank[0];
            m_wr_addr = waddr;
            m_wr_data = data;
            waddr = (waddr + 1) % FRAME_LEN;
            outst = 0;
        end else if (!outst && !en) begin
            waddr = 0;
        end
        m_wr_en = wr;
        if (start) outst = 1;
        m_start = start;
        m_miss = miss_set ? 1'b1 : (clr ? 1'b0 : m_miss);
        m_ovr  = ovr_set  ? 1'b1 : (clr ? 1'b0 : m_ovr);
    endtask

    task automatic check_outputs();
        chk("adc_start", adc_start, m_start);
        chk("wr_en", wr_en, m_wr_en);
        chk("wr_bank", wr_bank, m_wr_bank);
        chk("wr_addr", wr_addr, m_wr_addr);
        chk("wr_data", wr_data, m_wr_data);
        chk("frame_ready", frame_ready, q.size() > 0);
        chk("frame_bank", frame_bank, q.size() > 0 ? q[0] : 0);
        chk("tick_miss", tick_miss, m_miss);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic do_reset();
        rst_n = 0; enable = 0; adc_valid = 0; frame_ack = 0; clr_flags = 0; adc_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        check_outputs();
    endtask

    task automatic step(input bit en, input bit ack, input bit clr);
        enable = en; frame_ack = ack; clr_flags = clr;
        if (adc_start === 1'b1) begin
            pending = 1;
            if (rand_mode) delay = $urandom_range(1, 20);
            due = cyc + delay;
        end
        adc_valid = 1'b0;
        if (pending && cyc == due) begin
            adc_valid = 1'b1;
            adc_data = rand_mode ? SAMPLE_W'($urandom) : SAMPLE_W'(samp_idx);
            samp_idx++;
            pending = 0;
        end else if (rand_mode && !pending && $urandom_range(0, 15) == 0) begin
            adc_valid = 1'b1;
            adc_data = SAMPLE_W'($urandom);
        end
        model_step(en, adc_valid, adc_data, ack, clr);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (adc_start === 1'b1) start_q.push_back(cyc);
        if (wr_en === 1'b1) begin
            nwr++;
            wr_q.push_back(cyc);
            wa_q.push_back(int'(wr_addr));
        end
        if (frame_ready === 1'b1 && rdy_rise < 0) rdy_rise = cyc;
        if (rdy_rise >= 0 && frame_ready === 1'b0 && rdy_fall < 0) rdy_fall = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        bit en;
        do_reset();
        rand_mode = 0;
        delay = v.delay;
        for (int c = 0; c < v.n; c++) begin
            en = !(v.dis_at >= 0 && c >= v.dis_at && c < v.dis_at + v.dis_len);
            step(en, c == v.ack_at, c == v.clr_at);
        end
        chk("end_frame_ready", frame_ready, v.e_ready);
        chk("end_frame_bank", frame_bank, v.e_bank);
        chk("end_overrun", overrun, v.e_ovr);
        chk("end_tick_miss", tick_miss, v.e_miss);
        chk("end_write_count", nwr, v.e_nwr);
    endtask

    initial begin
        //         n   dly ack  clr  dis dlen rdy bank ovr miss nwr
        vecs[0] = '{ 90,  3,  -1,  -1, -1,  0, 1, 0, 0, 0,  8}; // basic rate
        vecs[1] = '{ 95,  3,  86,  -1, -1,  0, 0, 0, 0, 0,  9}; // handoff + ack
        vecs[2] = '{250,  3,  -1,  -1, -1,  0, 1, 0, 1, 0, 24}; // overrun
        vecs[3] = '{175,  3, 164,  -1, -1,  0, 1, 1, 0, 0, 17}; // ack with completion
        vecs[4] = '{ 58, 15,  -1,  -1, -1,  0, 0, 0, 0, 1,  2}; // missed tick
        vecs[5] = '{ 58, 15,  -1,  55, -1,  0, 0, 0, 0, 0,  2}; // clear flag
        vecs[6] = '{ 22, 15,  -1,  19, -1,  0, 0, 0, 0, 1,  0}; // set beats clear
        vecs[7] = '{ 80,  3,  -1,  -1, 52, 10, 0, 0, 0, 0,  6}; // disable mid-frame

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            case (i)
                0: begin
                    chk("start_0", qget(0, 0), 10);
                    chk("start_1", qget(0, 1), 20);
                    chk("start_2", qget(0, 2), 30);
                    chk("wr_0", qget(1, 0), 14);
                    chk("wr_1", qget(1, 1), 24);
                    for (int k = 0; k < 8; k++) chk("wr_addr_seq", qget(2, k), k);
                end
                1: begin
                    chk("ready_rise", rdy_rise, 85);
                    chk("ready_fall", rdy_fall, 87);
                    chk("next_bank", wr_bank, 1);
                    chk("next_addr", qget(2, 8), 0);
                end
                3: chk("resume_bank0", wr_bank, 0);
                4: begin
                    chk("miss_start_0", qget(0, 0), 10);
                    chk("miss_start_1", qget(0, 1), 30);
                    chk("miss_start_2", qget(0, 2), 50);
                    chk("miss_start_cnt", start_q.size(), 3);
                end
                7: begin
                    chk("reenable_wr_cycle", qget(1, 5), 76);
                    chk("reenable_wr_addr", qget(2, 5), 0);
                end
                default: ;
            endcase
        end

        // Asynchronous reset in the middle of a frame
        do_reset();
        rand_mode = 0;
        delay = 3;
        for (int c = 0; c < 55; c++) step(1'b1, 1'b0, 1'b0);
        #2 rst_n = 0;
        #1;
        chk("rst_adc_start", adc_start, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_frame_bank", frame_bank, 0);
        chk("rst_tick_miss", tick_miss, 0);
        chk("rst_overrun", overrun, 0);

        // Random traffic against the reference model
        do_reset();
        rand_mode = 1;
        begin
            bit en;
            en = 1;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(0, 199) == 0) en = !en;
                step(en, $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
